// File: rtl/a12_edge_qual_pkg.sv
// Shared mapper definitions for the A12 edge qualifier.
// FSM state type, low-time counter width, saturating increment.
package a12_edge_qual_pkg;

  localparam int A12Q_CTR_W = 4;

  typedef enum logic [1:0] {
    A12Q_LOW_WAIT,
    A12Q_ARMED,
    A12Q_HIGH
  } a12q_state_t;

  function automatic logic [A12Q_CTR_W-1:0] a12q_sat_inc(
    input logic [A12Q_CTR_W-1:0] val,
    input logic [A12Q_CTR_W-1:0] lim
  );
    if (val >= lim) return lim;
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/a12_edge_qual_m2_edge_det.sv
// M2 edge detector: 3-bit history of raw cpu_m2, one-clk edge strobes.
// Ports: clk, map_rst_n (sync, active low), cpu_m2 in; m2_ne, m2_pe out.
module m2_edge_det (
  input  logic clk,
  input  logic map_rst_n,
  input  logic cpu_m2,
  output logic m2_ne,
  output logic m2_pe
);

  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (!map_rst_n) begin
      hist <= 3'b000;
    end else begin
      hist <= {hist[1:0], cpu_m2};
    end
  end

  // Two older samples must agree before the edge counts.
  assign m2_ne = (hist == 3'b110);
  assign m2_pe = (hist == 3'b001);

endmodule

// File: rtl/a12_edge_qual.sv
// PPU A12 deglitch and rising-edge qualifier for the scanline IRQ counter.
// Ports: clk, map_rst_n, cpu_m2, ppu_a12, filt_en in; a12_level, a12_rise, rise_cnt[7:0] out.
module a12_edge_qual
  import a12_edge_qual_pkg::*;
#(
  parameter int SYNC_LEN   = 2,
  parameter int M2_LOW_MIN = 3
) (
  input  logic       clk,
  input  logic       map_rst_n,
  input  logic       cpu_m2,
  input  logic       ppu_a12,
  input  logic       filt_en,
  output logic       a12_level,
  output logic       a12_rise,
  output logic [7:0] rise_cnt
);

  localparam logic [A12Q_CTR_W-1:0] LOW_MIN =
    A12Q_CTR_W'(M2_LOW_MIN);

  logic [SYNC_LEN-1:0]   sync_q;
  logic                  a12d;
  logic                  m2_ne;
  logic                  m2_pe_unused;
  a12q_state_t           state_q;
  a12q_state_t           state_d;
  logic [A12Q_CTR_W-1:0] ctr_q;
  logic [A12Q_CTR_W-1:0] ctr_d;
  logic [A12Q_CTR_W-1:0] ctr_inc;
  logic                  rise_d;

  m2_edge_det u_m2 (
    .clk       (clk),
    .map_rst_n (map_rst_n),
    .cpu_m2    (cpu_m2),
    .m2_ne     (m2_ne),
    .m2_pe     (m2_pe_unused)
  );

  // Level only moves when the whole window agrees.
  always_ff @(posedge clk) begin
    if (!map_rst_n) begin
      sync_q <= '0;
      a12d   <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_LEN'(ppu_a12);
      if (&sync_q) begin
        a12d <= 1'b1;
      end else if (~|sync_q) begin
        a12d <= 1'b0;
      end
    end
  end

  assign a12_level = a12d;
  assign ctr_inc   = a12q_sat_inc(ctr_q, LOW_MIN);

  // Rise wins over a same-cycle m2_ne: the
  // pre-increment count decides.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    rise_d  = 1'b0;
    unique case (state_q)
      A12Q_LOW_WAIT: begin
        if (a12d) begin
          state_d = A12Q_HIGH;
          rise_d  = ~filt_en;
        end else if (m2_ne) begin
          ctr_d = ctr_inc;
          if (ctr_inc >= LOW_MIN) begin
            state_d = A12Q_ARMED;
          end
        end
      end
      A12Q_ARMED: begin
        ctr_d = LOW_MIN;
        if (a12d) begin
          state_d = A12Q_HIGH;
          rise_d  = 1'b1;
        end
      end
      A12Q_HIGH: begin
        if (!a12d) begin
          state_d = A12Q_LOW_WAIT;
          ctr_d   = '0;
        end
      end
      default: begin
        state_d = A12Q_LOW_WAIT;
        ctr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!map_rst_n) begin
      state_q  <= A12Q_LOW_WAIT;
      ctr_q    <= '0;
      a12_rise <= 1'b0;
      rise_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      a12_rise <= rise_d;
      if (rise_d) begin
        rise_cnt <= rise_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_a12_edge_qual.sv
// Randomized scoreboard bench for a12_edge_qual.
// Reference model runs on sample histories; monitor compares each clk.
module tb_a12_edge_qual;

  localparam int SYNC_LEN   = 2;
  localparam int M2_LOW_MIN = 3;
  localparam int NCYC       = 16000;

  logic       clk = 1'b0;
  logic       map_rst_n;
  logic       cpu_m2;
  logic       ppu_a12;
  logic       filt_en;
  logic       a12_level;
  logic       a12_rise;
  logic [7:0] rise_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       lvl;
    logic       rise;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  a12_edge_qual #(
    .SYNC_LEN   (SYNC_LEN),
    .M2_LOW_MIN (M2_LOW_MIN)
  ) dut (
    .clk       (clk),
    .map_rst_n (map_rst_n),
    .cpu_m2    (cpu_m2),
    .ppu_a12   (ppu_a12),
    .filt_en   (filt_en),
    .a12_level (a12_level),
    .a12_rise  (a12_rise),
    .rise_cnt  (rise_cnt)
  );

  // Reference: a12 level follows unanimous sample windows;
  // a rise qualifies if filter off or enough M2 falls were
  // seen since the level last dropped (not counting the
  // rise cycle itself).
  bit   m_samp[$];
  bit   m_m2[$];
  bit   m_lvl;
  bit   m_high;
  int   m_lows;
  int   m_cnt;
  bit   m_ne;
  bit   m_pulse;
  bit   m_all1;
  bit   m_all0;
  exp_t m_e;

  always @(posedge clk) begin
    if (!map_rst_n) begin
      m_samp.delete();
      m_m2.delete();
      for (int i = 0; i < SYNC_LEN; i++) m_samp.push_back(1'b0);
      for (int i = 0; i < 3; i++) m_m2.push_back(1'b0);
      m_lvl   = 1'b0;
      m_high  = 1'b0;
      m_lows  = 0;
      m_cnt   = 0;
      m_pulse = 1'b0;
    end else begin
      m_ne    = m_m2[0] && m_m2[1] && !m_m2[2];
      m_pulse = 1'b0;
      if (!m_high && m_lvl) begin
        m_high  = 1'b1;
        m_pulse = !filt_en || (m_lows >= M2_LOW_MIN);
      end else if (m_high && !m_lvl) begin
        m_high = 1'b0;
        m_lows = 0;
      end else if (!m_high && m_ne) begin
        m_lows++;
      end
      m_all1 = 1'b1;
      m_all0 = 1'b1;
      foreach (m_samp[i]) begin
        m_all1 &= m_samp[i];
        m_all0 &= !m_samp[i];
      end
      if (m_all1) m_lvl = 1'b1;
      else if (m_all0) m_lvl = 1'b0;
      m_samp.push_back(ppu_a12);
      void'(m_samp.pop_front());
      m_m2.push_back(cpu_m2);
      void'(m_m2.pop_front());
      if (m_pulse) m_cnt = (m_cnt + 1) % 256;
    end
    m_e.lvl  = m_lvl;
    m_e.rise = m_pulse;
    m_e.cnt  = 8'(m_cnt);
    sb.push_back(m_e);
  end

  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      mon_e = sb.pop_front();
      vectors++;
      if ({a12_level, a12_rise, rise_cnt} !== mon_e) begin
        miscompares++;
        $display("FAIL outputs at %0t: got lvl=%b rise=%b cnt=%0d, want lvl=%b rise=%b cnt=%0d",
                 $time, a12_level, a12_rise, rise_cnt,
                 mon_e.lvl, mon_e.rise, mon_e.cnt);
      end
    end
  end

  int m2_left;
  int a12_left;

  initial begin
    // A12 held high through reset: level rises, no pulse.
    map_rst_n = 1'b0;
    cpu_m2    = 1'b0;
    ppu_a12   = 1'b1;
    filt_en   = 1'b1;
    m2_left   = 1;
    a12_left  = 12;
    repeat (3) @(negedge clk);
    map_rst_n = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      m2_left = m2_left - 1;
      if (m2_left <= 0) begin
        cpu_m2  = ~cpu_m2;
        m2_left = int'($urandom_range(1, 4));
        if ($urandom_range(0, 99) < 3)
          m2_left = int'($urandom_range(20, 60));
      end
      a12_left = a12_left - 1;
      if (a12_left <= 0) begin
        ppu_a12 = ~ppu_a12;
        if (ppu_a12) a12_left = int'($urandom_range(1, 12));
        else a12_left = int'($urandom_range(1, 30));
      end
      if ($urandom_range(0, 199) == 0) filt_en = ~filt_en;
      map_rst_n = !((c > 12000) && ($urandom_range(0, 999) == 0));
    end
    map_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
